// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the register-file write port between the
// ALU writeback (requester 0) and the load writeback (requester 1).
// Accepted writes are presented on the port one cycle later from registers.
// Writes to register 0 are acknowledged but never reach the port.
module regfile_write_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_ready,
   output logic                  regWrite,
   output logic [ADDR_WIDTH-1:0] writeAddress,
   output logic [DATA_WIDTH-1:0] writeData,
   output logic                  grant_id,
   output logic [CNT_WIDTH-1:0]  contention_count
);

   logic rrPtr;
   logic accepting;
   logic live0;
   logic live1;
   logic zero0;
   logic zero1;
   logic grant0;
   logic grant1;
   logic contention;

   // Arbitration: zero-address requests bypass arbitration; live requests
   // compete, with rrPtr breaking ties. Reset and stall block all acceptance.
   always_comb begin
      accepting  = !reset && !stall;
      live0      = req0_valid && (req0_addr != '0);
      live1      = req1_valid && (req1_addr != '0);
      zero0      = req0_valid && (req0_addr == '0);
      zero1      = req1_valid && (req1_addr == '0);
      grant0     = accepting && live0 && (!live1 || !rrPtr);
      grant1     = accepting && live1 && (!live0 || rrPtr);
      contention = accepting && live0 && live1;
      req0_ready = grant0 || (accepting && zero0);
      req1_ready = grant1 || (accepting && zero1);
   end

   // Write-port registers, round-robin pointer and saturating contention counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         regWrite         <= 1'b0;
         writeAddress     <= '0;
         writeData        <= '0;
         grant_id         <= 1'b0;
         rrPtr            <= 1'b0;
         contention_count <= '0;
      end else begin
         regWrite <= grant0 || grant1;
         if (grant0) begin
            writeAddress <= req0_addr;
            writeData    <= req0_data;
            grant_id     <= 1'b0;
            rrPtr        <= 1'b1;
         end else if (grant1) begin
            writeAddress <= req1_addr;
            writeData    <= req1_data;
            grant_id     <= 1'b1;
            rrPtr        <= 1'b0;
         end
         if (contention && (contention_count != '1)) begin
            contention_count <= contention_count + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the arbitration rules.
module tb_regfile_write_arbiter;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        req0_valid;
   logic [4:0]  req0_addr;
   logic [31:0] req0_data;
   logic        req0_ready;
   logic        req1_valid;
   logic [4:0]  req1_addr;
   logic [31:0] req1_data;
   logic        req1_ready;
   logic        regWrite;
   logic [4:0]  writeAddress;
   logic [31:0] writeData;
   logic        grant_id;
   logic [15:0] contention_count;

   logic        sReady0;
   logic        sReady1;
   logic        sRegWrite;
   logic [4:0]  sAddr;
   logic [31:0] sData;
   logic        sGid;
   logic [3:0]  sCount;

   int checks = 0;
   int passed = 0;

   // Model state
   bit          mRr;
   bit          mRegWrite;
   logic [4:0]  mAddr;
   logic [31:0] mData;
   bit          mGid;
   int          mCnt;
   int          mCntS;
   int          mWinner;
   bit          mCont;
   bit          expReady0;
   bit          expReady1;

   regfile_write_arbiter dut (
      .clk(clk), .reset(reset), .stall(stall),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
      .regWrite(regWrite), .writeAddress(writeAddress), .writeData(writeData),
      .grant_id(grant_id), .contention_count(contention_count)
   );

   regfile_write_arbiter #(.CNT_WIDTH(4)) dutSmall (
      .clk(clk), .reset(reset), .stall(stall),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(sReady0),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(sReady1),
      .regWrite(sRegWrite), .writeAddress(sAddr), .writeData(sData),
      .grant_id(sGid), .contention_count(sCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decide who wins this cycle from the current inputs (before the edge).
   task automatic modelComb();
      bit l0, l1, open;
      l0   = req0_valid && (req0_addr != 5'd0);
      l1   = req1_valid && (req1_addr != 5'd0);
      open = !reset && !stall;
      if (!open)          mWinner = -1;
      else if (l0 && l1)  mWinner = mRr ? 1 : 0;
      else if (l0)        mWinner = 0;
      else if (l1)        mWinner = 1;
      else                mWinner = -1;
      mCont     = open && l0 && l1;
      expReady0 = open && req0_valid && ((req0_addr == 5'd0) || (mWinner == 0));
      expReady1 = open && req1_valid && ((req1_addr == 5'd0) || (mWinner == 1));
   endtask

   // Apply the decided outcome at the clock edge.
   task automatic modelClock();
      if (reset) begin
         mRr = 0; mRegWrite = 0; mAddr = '0; mData = '0; mGid = 0; mCnt = 0; mCntS = 0;
      end else begin
         mRegWrite = (mWinner >= 0);
         if (mWinner == 0) begin
            mAddr = req0_addr; mData = req0_data; mGid = 0; mRr = 1;
         end else if (mWinner == 1) begin
            mAddr = req1_addr; mData = req1_data; mGid = 1; mRr = 0;
         end
         if (mCont) begin
            if (mCnt < 65535) mCnt++;
            if (mCntS < 15) mCntS++;
         end
      end
   endtask

   task automatic settle();
      #1;
      modelComb();
   endtask

   task automatic tick();
      @(posedge clk);
      modelClock();
      #1;
   endtask

   task automatic drive(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                        input bit v1, input logic [4:0] a1, input logic [31:0] d1);
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
   endtask

   task automatic doReset();
      reset = 1'b1; stall = 1'b0;
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      settle();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0;
      drive(1, 5'd5, 32'h1, 1, 5'd6, 32'h2);
      settle();
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
         $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
      else passed++;
      tick();
      checks++;
      if (regWrite !== 1'b0 || writeAddress !== 5'd0 || writeData !== 32'd0 || grant_id !== 1'b0)
         $display("FAIL reset_port: got we=%b a=%0d d=%h g=%b want 0/0/0/0", regWrite, writeAddress, writeData, grant_id);
      else passed++;
      checks++;
      if (contention_count !== 16'd0 || sCount !== 4'd0)
         $display("FAIL reset_count: got %0d/%0d want 0", contention_count, sCount);
      else passed++;
      reset = 1'b0;
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
   endtask

   task automatic test_single();
      doReset();
      drive(1, 5'd5, 32'hAAAAAAAA, 0, 5'd0, 32'd0);
      settle();
      checks++;
      if (req0_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", req0_ready);
      else passed++;
      tick();
      checks++;
      if (regWrite !== 1'b1 || writeAddress !== 5'd5 || writeData !== 32'hAAAAAAAA || grant_id !== 1'b0)
         $display("FAIL single_write: got we=%b a=%0d d=%h g=%b want 1/5/aaaaaaaa/0", regWrite, writeAddress, writeData, grant_id);
      else passed++;
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      settle();
      tick();
      checks++;
      if (regWrite !== 1'b0) $display("FAIL single_pulse: got we=%b want 0", regWrite);
      else passed++;
   endtask

   task automatic test_alternate();
      doReset();
      for (int i = 0; i < 4; i++) begin
         drive(1, 5'd2, 32'h12345678, 1, 5'd3, 32'hBBBBBBBB);
         settle();
         checks++;
         if (req0_ready !== 1'((i % 2) == 0) || req1_ready !== 1'((i % 2) == 1))
            $display("FAIL alt_ready[%0d]: got %b%b want r0=%b", i, req0_ready, req1_ready, 1'((i % 2) == 0));
         else passed++;
         tick();
         checks++;
         if (regWrite !== 1'b1 || grant_id !== 1'(i % 2) || writeAddress !== ((i % 2) == 0 ? 5'd2 : 5'd3))
            $display("FAIL alt_grant[%0d]: got we=%b g=%b a=%0d want 1/%0d", i, regWrite, grant_id, writeAddress, i % 2);
         else passed++;
      end
      checks++;
      if (contention_count !== 16'd4) $display("FAIL alt_count: got %0d want 4", contention_count);
      else passed++;
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
   endtask

   task automatic test_zero_addr();
      doReset();
      drive(1, 5'd0, 32'hFFFFFFFF, 1, 5'd30, 32'h11111111);
      settle();
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b1)
         $display("FAIL zero_ready: got %b%b want 11", req0_ready, req1_ready);
      else passed++;
      tick();
      checks++;
      if (regWrite !== 1'b1 || writeAddress !== 5'd30 || writeData !== 32'h11111111 || grant_id !== 1'b1)
         $display("FAIL zero_write: got we=%b a=%0d d=%h g=%b want 1/30/11111111/1", regWrite, writeAddress, writeData, grant_id);
      else passed++;
      checks++;
      if (contention_count !== 16'd0) $display("FAIL zero_count: got %0d want 0", contention_count);
      else passed++;
      drive(1, 5'd4, 32'h44, 1, 5'd9, 32'h99);
      settle();
      tick();
      checks++;
      if (grant_id !== 1'b0 || writeAddress !== 5'd4)
         $display("FAIL zero_rrptr: got g=%b a=%0d want 0/4", grant_id, writeAddress);
      else passed++;
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
   endtask

   task automatic test_stall();
      doReset();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 5'd7, 32'h7, 1, 5'd8, 32'h8);
         settle();
         checks++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
            $display("FAIL stall_ready[%0d]: got %b%b want 00", i, req0_ready, req1_ready);
         else passed++;
         tick();
         checks++;
         if (regWrite !== 1'b0 || contention_count !== 16'd0)
            $display("FAIL stall_hold[%0d]: got we=%b cnt=%0d want 0/0", i, regWrite, contention_count);
         else passed++;
      end
      stall = 1'b0;
      settle();
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
         $display("FAIL stall_release_ready: got %b%b want 10", req0_ready, req1_ready);
      else passed++;
      tick();
      checks++;
      if (regWrite !== 1'b1 || grant_id !== 1'b0 || writeAddress !== 5'd7)
         $display("FAIL stall_first: got we=%b g=%b a=%0d want 1/0/7", regWrite, grant_id, writeAddress);
      else passed++;
      drive(0, 5'd0, 32'd0, 1, 5'd8, 32'h8);
      settle();
      tick();
      checks++;
      if (regWrite !== 1'b1 || grant_id !== 1'b1 || writeAddress !== 5'd8)
         $display("FAIL stall_second: got we=%b g=%b a=%0d want 1/1/8", regWrite, grant_id, writeAddress);
      else passed++;
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
   endtask

   task automatic test_saturate();
      doReset();
      drive(1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2);
      for (int i = 0; i < 20; i++) begin
         settle();
         tick();
         checks++;
         if (sCount !== 4'((i + 1 > 15) ? 15 : i + 1) || contention_count !== 16'(i + 1))
            $display("FAIL sat_count[%0d]: got small=%0d big=%0d want %0d/%0d", i, sCount, contention_count,
                     (i + 1 > 15) ? 15 : i + 1, i + 1);
         else passed++;
      end
      checks++;
      if (sCount !== 4'd15) $display("FAIL sat_final: got %0d want 15", sCount);
      else passed++;
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
   endtask

   task automatic test_reset_mid();
      doReset();
      drive(1, 5'd12, 32'hC, 0, 5'd0, 32'd0);
      settle();
      tick();
      drive(0, 5'd0, 32'd0, 1, 5'd31, 32'hDEADBEEF);
      reset = 1'b1;
      settle();
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
         $display("FAIL mid_ready: got %b%b want 00", req0_ready, req1_ready);
      else passed++;
      tick();
      reset = 1'b0;
      checks++;
      if (regWrite !== 1'b0 || writeAddress !== 5'd0 || writeData !== 32'd0 || grant_id !== 1'b0 || contention_count !== 16'd0)
         $display("FAIL mid_outputs: got we=%b a=%0d d=%h g=%b c=%0d want all 0", regWrite, writeAddress, writeData, grant_id, contention_count);
      else passed++;
      drive(1, 5'd3, 32'h33, 1, 5'd31, 32'hDEADBEEF);
      settle();
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
         $display("FAIL mid_arb_ready: got %b%b want 10", req0_ready, req1_ready);
      else passed++;
      tick();
      checks++;
      if (regWrite !== 1'b1 || grant_id !== 1'b0 || writeAddress !== 5'd3)
         $display("FAIL mid_next_grant: got we=%b g=%b a=%0d want 1/0/3", regWrite, grant_id, writeAddress);
      else passed++;
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
   endtask

   task automatic test_random();
      bit acc0, acc1;
      doReset();
      acc0 = 1; acc1 = 1;
      for (int i = 0; i < 300; i++) begin
         if (!req0_valid || acc0) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            req0_data  = $urandom;
         end
         if (!req1_valid || acc1) begin
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            req1_data  = $urandom;
         end
         stall = ($urandom_range(0, 5) == 0);
         settle();
         acc0 = expReady0;
         acc1 = expReady1;
         checks++;
         if (req0_ready !== expReady0 || req1_ready !== expReady1)
            $display("FAIL rand_ready[%0d]: got %b%b want %b%b", i, req0_ready, req1_ready, expReady0, expReady1);
         else passed++;
         tick();
         checks++;
         if (regWrite !== mRegWrite || writeAddress !== mAddr || writeData !== mData || grant_id !== mGid)
            $display("FAIL rand_port[%0d]: got we=%b a=%0d d=%h g=%b want %b/%0d/%h/%b", i,
                     regWrite, writeAddress, writeData, grant_id, mRegWrite, mAddr, mData, mGid);
         else passed++;
         checks++;
         if (contention_count !== 16'(mCnt) || sCount !== 4'(mCntS))
            $display("FAIL rand_count[%0d]: got %0d/%0d want %0d/%0d", i, contention_count, sCount, mCnt, mCntS);
         else passed++;
      end
      stall = 1'b0;
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0;
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      mRr = 0; mRegWrite = 0; mAddr = '0; mData = '0; mGid = 0; mCnt = 0; mCntS = 0;
      mWinner = -1; mCont = 0; expReady0 = 0; expReady1 = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_alternate();
      test_zero_addr();
      test_stall();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
